// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder/subtractor built around one 1-bit full adder.
// A command is taken in IDLE, bits are processed LSB first in RUN (one per
// clock), and DONE presents a one-cycle done pulse with registered results.

// Single-bit full adder shared by the serial datapath.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum_out,
   output logic             cout_out,
   output logic             ovf_out
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sreg_q, a_sreg_d;
   logic [WIDTH-1:0] b_sreg_q, b_sreg_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic fa_sum;
   logic fa_cout;

   full_adder u_fa (
      .a    (a_sreg_q[0]),
      .b    (b_sreg_q[0]),
      .cin  (carry_q),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         a_sreg_q <= '0;
         b_sreg_q <= '0;
         res_q    <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         sum_q    <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sreg_q <= a_sreg_d;
         b_sreg_q <= b_sreg_d;
         res_q    <= res_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         sum_q    <= sum_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
      end
   end

   // Next-state logic: accept, serial bit step, and completion capture.
   always_comb begin
      state_d  = state_q;
      a_sreg_d = a_sreg_q;
      b_sreg_d = b_sreg_q;
      res_d    = res_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      sum_d    = sum_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               a_sreg_d = a_in;
               b_sreg_d = sub ? ~b_in : b_in;
               carry_d  = sub ? 1'b1 : cin_in;
               cnt_d    = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            a_sreg_d = a_sreg_q >> 1;
            b_sreg_d = b_sreg_q >> 1;
            res_d    = {fa_sum, res_q[WIDTH-1:1]};
            carry_d  = fa_cout;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               // carry_q is the carry into the MSB on this step
               sum_d   = {fa_sum, res_q[WIDTH-1:1]};
               cout_d  = fa_cout;
               ovf_d   = carry_q ^ fa_cout;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy     = (state_q != IDLE);
   assign done     = (state_q == DONE);
   assign sum_out  = sum_q;
   assign cout_out = cout_q;
   assign ovf_out  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8: arithmetic, latency,
// handshake, async reset abort and a boundary/random operand sweep.
module tb_serial_add_ctrl;

   logic       clk;
   logic       rst;
   logic       start;
   logic       sub;
   logic [7:0] a_in;
   logic [7:0] b_in;
   logic       cin_in;
   logic       busy;
   logic       done;
   logic [7:0] sum_out;
   logic       cout_out;
   logic       ovf_out;

   int n_assert = 0;
   int n_fail   = 0;

   // Last completed result, used to confirm outputs hold during RUN.
   logic [7:0] prev_sum  = 8'h00;
   logic       prev_cout = 1'b0;
   logic       prev_ovf  = 1'b0;

   serial_add_ctrl #(.WIDTH(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .sub      (sub),
      .a_in     (a_in),
      .b_in     (b_in),
      .cin_in   (cin_in),
      .busy     (busy),
      .done     (done),
      .sum_out  (sum_out),
      .cout_out (cout_out),
      .ovf_out  (ovf_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Arithmetic reference: whole-word addition of A with (possibly inverted) B.
   task automatic model(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic c, output logic [7:0] rs, output logic rc,
                        output logic rv);
      logic [7:0] bb;
      logic       ci;
      logic [8:0] t;
      bb = s ? ~b : b;
      ci = s ? 1'b1 : c;
      t  = {1'b0, a} + {1'b0, bb} + {8'h00, ci};
      rs = t[7:0];
      rc = t[8];
      rv = (a[7] == bb[7]) && (t[7] != a[7]);
   endtask

   // One full operation: accept, latency count, result check, done width.
   // With interfere set, start is re-asserted mid-RUN with other operands.
   task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic s, input logic c, input logic [7:0] es,
                         input logic ec, input logic ev, input logic interfere);
      int n;
      a_in   = a;
      b_in   = b;
      sub    = s;
      cin_in = c;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk({tag, ".busy_rise"}, 32'(busy), 32'd1);
      n = 0;
      while (!done && n < 20) begin
         @(posedge clk);
         #1;
         n++;
         if (interfere && n == 3) begin
            a_in   = 8'hAA;
            b_in   = 8'h55;
            sub    = 1'b1;
            start  = 1'b1;
         end
         if (interfere && n == 5) start = 1'b0;
         if (!done && n == 4) begin
            chk({tag, ".hold_sum"},  32'(sum_out),  32'(prev_sum));
            chk({tag, ".hold_cout"}, 32'(cout_out), 32'(prev_cout));
            chk({tag, ".hold_ovf"},  32'(ovf_out),  32'(prev_ovf));
         end
      end
      chk({tag, ".latency"}, 32'(n), 32'd8);
      chk({tag, ".sum"},  32'(sum_out),  32'(es));
      chk({tag, ".cout"}, 32'(cout_out), 32'(ec));
      chk({tag, ".ovf"},  32'(ovf_out),  32'(ev));
      prev_sum  = es;
      prev_cout = ec;
      prev_ovf  = ev;
      @(posedge clk);
      #1;
      chk({tag, ".done_fall"}, 32'(done), 32'd0);
      chk({tag, ".idle"},      32'(busy), 32'd0);
   endtask

   logic [7:0] vals [8] = '{8'h00, 8'h01, 8'h0F, 8'h55, 8'h7F, 8'h80, 8'hAA, 8'hFF};

   initial begin : stim
      int          n;
      logic [7:0]  ms;
      logic        mc;
      logic        mv;
      logic [7:0]  ra;
      logic [7:0]  rb;

      rst    = 1'b1;
      start  = 1'b0;
      sub    = 1'b0;
      a_in   = 8'h00;
      b_in   = 8'h00;
      cin_in = 1'b0;
      #1;
      chk("reset.busy", 32'(busy),     32'd0);
      chk("reset.done", 32'(done),     32'd0);
      chk("reset.sum",  32'(sum_out),  32'd0);
      chk("reset.cout", 32'(cout_out), 32'd0);
      chk("reset.ovf",  32'(ovf_out),  32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Directed arithmetic
      run_op("add_0f_01",  8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0);
      run_op("add_ff_01",  8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      run_op("add_7f_01",  8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
      run_op("add_7f_c1",  8'h7F, 8'h00, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0);
      run_op("sub_05_07",  8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0);
      run_op("sub_80_01",  8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0);
      run_op("sub_cin_ig", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);

      // start during RUN is ignored; first result stands
      run_op("mid_start",  8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b1);

      // start held high across DONE: back-to-back ops, 10 cycles apart
      a_in   = 8'h7F;
      b_in   = 8'h01;
      sub    = 1'b0;
      cin_in = 1'b0;
      start  = 1'b1;
      @(posedge clk);
      #1;
      n = 0;
      while (!done && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("hold1.latency", 32'(n), 32'd8);
      chk("hold1.sum", 32'(sum_out), 32'h80);
      chk("hold1.ovf", 32'(ovf_out), 32'd1);
      a_in = 8'hFF;
      b_in = 8'h01;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!done && n < 30);
      start = 1'b0;
      chk("hold2.spacing", 32'(n), 32'd10);
      chk("hold2.sum",  32'(sum_out),  32'h00);
      chk("hold2.cout", 32'(cout_out), 32'd1);
      chk("hold2.ovf",  32'(ovf_out),  32'd0);
      @(posedge clk);
      #1;
      chk("hold2.done_fall", 32'(done), 32'd0);
      @(posedge clk);
      #1;
      chk("hold2.no_third", 32'(busy), 32'd0);
      prev_sum  = 8'h00;
      prev_cout = 1'b1;
      prev_ovf  = 1'b0;

      // Leave a nonzero result so the reset clear is visible
      run_op("pre_rst", 8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0);

      // Async reset in the middle of bit 4
      a_in   = 8'h12;
      b_in   = 8'h34;
      sub    = 1'b0;
      cin_in = 1'b0;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("abort.busy", 32'(busy),     32'd0);
      chk("abort.done", 32'(done),     32'd0);
      chk("abort.sum",  32'(sum_out),  32'd0);
      chk("abort.cout", 32'(cout_out), 32'd0);
      chk("abort.ovf",  32'(ovf_out),  32'd0);
      #1;
      rst = 1'b0;
      n = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (done) n++;
      end
      chk("abort.no_done", 32'(n), 32'd0);
      prev_sum  = 8'h00;
      prev_cout = 1'b0;
      prev_ovf  = 1'b0;
      run_op("post_rst", 8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0, 1'b0);

      // Boundary operand sweep in all three modes
      foreach (vals[i]) begin
         foreach (vals[j]) begin
            for (int unsigned m = 0; m < 3; m++) begin
               model(vals[i], vals[j], m == 2, m == 1, ms, mc, mv);
               run_op("sweep", vals[i], vals[j], m == 2, m == 1, ms, mc, mv, 1'b0);
            end
         end
      end

      // Random operands
      for (int unsigned k = 0; k < 200; k++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         model(ra, rb, k[0], k[1], ms, mc, mv);
         run_op("random", ra, rb, k[0], k[1], ms, mc, mv, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
